// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: streams RK0..RK(NUM_ROUNDS) one per valid/ready transfer.
// Holds both the schedule controller and the byte S-box it instantiates for SubWord.

module sbox_module (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign data_out = SBOX[8 * (255 - int'(data_in)) +: 8];

endmodule

module aes_key_expand #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter logic [7:0]  RCON_INIT  = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         done
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e       state_q;
    logic [127:0] key_q;
    logic [7:0]   rcon_q;
    logic [3:0]   idx_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_key;
    logic [7:0]   rcon_next;

    assign {w0, w1, w2, w3} = key_q;
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        sbox_module u_sbox (
            .data_in (rot_w[8*i +: 8]),
            .data_out(sub_w[8*i +: 8])
        );
    end

    assign t_w       = sub_w ^ {rcon_q, 24'h0};
    assign n0        = w0 ^ t_w;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign next_key  = {n0, n1, n2, n3};
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    assign rk_data = key_q;
    assign rk_idx  = idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            key_q    <= '0;
            idx_q    <= '0;
            rcon_q   <= RCON_INIT;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        key_q    <= key_in;
                        idx_q    <= '0;
                        rcon_q   <= RCON_INIT;
                        state_q  <= StEmit;
                        busy     <= 1'b1;
                        rk_valid <= 1'b1;
                    end
                end
                StEmit: begin
                    // rk_valid is always high here, so rk_ready alone marks a transfer.
                    if (rk_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_q  <= StIdle;
                            busy     <= 1'b0;
                            rk_valid <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            key_q  <= next_key;
                            idx_q  <= idx_q + 4'd1;
                            rcon_q <= rcon_next;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 schedule, zero key, backpressure,
// ignored start, mid-run reset, back-to-back runs and a NUM_ROUNDS=1 instance.

module tb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] OTHER_KEY = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, rk_ready, busy, rk_valid, done;
    logic [127:0] key_in, rk_data;
    logic [3:0]   rk_idx;

    logic         s_start, s_ready, s_busy, s_valid, s_done;
    logic [127:0] s_key, s_data;
    logic [3:0]   s_idx;

    int checks = 0;
    int errors = 0;

    logic [127:0] fips_rk [11];

    aes_key_expand u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .key_in  (key_in),
        .busy    (busy),
        .rk_valid(rk_valid),
        .rk_ready(rk_ready),
        .rk_data (rk_data),
        .rk_idx  (rk_idx),
        .done    (done)
    );

    aes_key_expand #(.NUM_ROUNDS(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (s_start),
        .key_in  (s_key),
        .busy    (s_busy),
        .rk_valid(s_valid),
        .rk_ready(s_ready),
        .rk_data (s_data),
        .rk_idx  (s_idx),
        .done    (s_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expects RK0 on the outputs with rk_ready high; optionally pulses start at index ign_at.
    task automatic run_seq(input string tag, input int ign_at);
        for (int i = 0; i <= 10; i++) begin
            check({tag, "_valid"}, rk_valid, 1);
            check({tag, "_busy"}, busy, 1);
            check({tag, "_data"}, rk_data, fips_rk[i]);
            check({tag, "_idx"}, rk_idx, 128'(i));
            check({tag, "_done_low"}, done, 0);
            if (i == ign_at) begin
                start  = 1'b1;
                key_in = OTHER_KEY;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        check({tag, "_end_valid"}, rk_valid, 0);
        check({tag, "_end_busy"}, busy, 0);
        check({tag, "_end_data"}, rk_data, fips_rk[10]);
        check({tag, "_end_idx"}, rk_idx, 10);
    endtask

    initial begin
        int k;
        int cyc;
        fips_rk = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6
        };
        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        s_start  = 1'b0;
        s_ready  = 1'b0;
        s_key    = '0;
        tick();
        tick();
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", rk_data, 0);
        check("rst_idx", rk_idx, 0);
        rst_n = 1'b1;
        tick();

        // FIPS-197 key, key_in changed after the accepted start must not matter.
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start    = 1'b0;
        key_in   = OTHER_KEY;
        rk_ready = 1'b1;
        run_seq("fips", -1);

        // Start in the done cycle with the zero key.
        start  = 1'b1;
        key_in = '0;
        tick();
        start = 1'b0;
        check("b2b_rk0", rk_data, 0);
        check("b2b_idx0", rk_idx, 0);
        check("b2b_valid", rk_valid, 1);
        tick();
        check("zero_rk1", rk_data, 128'h62636363626363636263636362636363);
        check("zero_idx1", rk_idx, 1);
        tick();
        check("zero_rk2", rk_data, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        cyc = 0;
        while (!done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("zero_done", done, 1);
        tick();
        check("zero_done_pulse", done, 0);

        // Random backpressure.
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        k     = 0;
        cyc   = 0;
        while (k <= 10 && cyc < 300) begin
            rk_ready = 1'($urandom_range(0, 1));
            check("bp_valid", rk_valid, 1);
            check("bp_data", rk_data, fips_rk[k]);
            check("bp_idx", rk_idx, 128'(k));
            check("bp_done_low", done, 0);
            tick();
            if (rk_ready) k++;
            cyc++;
        end
        check("bp_count", 128'(k), 11);
        check("bp_done", done, 1);
        rk_ready = 1'b1;
        tick();
        check("bp_done_pulse", done, 0);

        // Start while busy is ignored.
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        run_seq("ign", 4);
        tick();
        check("ign_idle_valid", rk_valid, 0);

        // Reset at rk_idx=6, then a clean run.
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_idx6", rk_idx, 6);
        rst_n = 1'b0;
        tick();
        check("mid_valid", rk_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_data", rk_data, 0);
        rst_n = 1'b1;
        tick();
        check("mid_no_partial", rk_valid, 0);
        key_in = FIPS_KEY;
        start  = 1'b1;
        tick();
        start = 1'b0;
        run_seq("rerun", -1);
        tick();

        // NUM_ROUNDS=1 instance.
        s_key   = FIPS_KEY;
        s_start = 1'b1;
        s_ready = 1'b1;
        tick();
        s_start = 1'b0;
        check("n1_valid0", s_valid, 1);
        check("n1_busy0", s_busy, 1);
        check("n1_rk0", s_data, fips_rk[0]);
        check("n1_idx0", s_idx, 0);
        tick();
        check("n1_rk1", s_data, fips_rk[1]);
        check("n1_idx1", s_idx, 1);
        check("n1_done_low", s_done, 0);
        tick();
        check("n1_done", s_done, 1);
        check("n1_end_valid", s_valid, 0);
        check("n1_end_busy", s_busy, 0);
        check("n1_end_idx", s_idx, 1);
        tick();
        check("n1_done_pulse", s_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule that accepts a 128-bit cipher key and streams the round keys RK0..RK10, one per accepted transfer, to the round datapath. It sits upstream of the AddRoundKey stage. It feeds the S-box: four sbox_module instances perform SubWord on the rotated last word of the current round key. One round key is produced per cycle under a valid/ready handshake with backpressure.

Parameters:
NUM_ROUNDS, 10, index of the last round key emitted; legal range 1..10; default gives the full AES-128 schedule of 11 keys.
RCON_INIT, 8'h01, Rcon value used to derive RK1 from RK0.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous reset, active low.
start  in  1  loads key_in and begins expansion; honoured only when busy=0.
key_in  in  128  cipher key; key_in[127:120] is byte 0 (FIPS-197 order).
busy  out  1  high from the cycle after an accepted start until the cycle after the final handshake.
rk_valid  out  1  rk_data holds a valid round key.
rk_ready  in  1  consumer accepts rk_data when rk_valid=1 and rk_ready=1.
rk_data  out  128  current round key, same byte order as key_in.
rk_idx  out  4  round index of rk_data, 0..NUM_ROUNDS.
done  out  1  one-cycle pulse after RKNUM_ROUNDS is accepted.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, rk_valid=0, rk_data=0, rk_idx=0, done=0; internal rcon=RCON_INIT. Reset mid-expansion aborts immediately. No partial key is emitted afterwards.
- FSM states: IDLE and EMIT.
  - IDLE: if start=1 at edge N, then key_reg<=key_in, rk_idx<=0, rcon<=RCON_INIT, go to EMIT. At N+1: rk_valid=1, busy=1, rk_data=key_in (RK0). Latency from start to first key is 1 cycle.
  - EMIT, no handshake: all outputs hold stable (AXI-style). rk_valid never drops without a transfer.
  - EMIT, handshake and rk_idx<NUM_ROUNDS: key_reg<=next_key, rk_idx<=rk_idx+1, rcon<=xtime(rcon), stay in EMIT.
  - EMIT, handshake and rk_idx==NUM_ROUNDS: go to IDLE. Next cycle: rk_valid=0, busy=0, done=1 for exactly one cycle. rk_data and rk_idx hold their last values.
- next_key computation (combinational, from key_reg = {w0,w1,w2,w3}, 32-bit words, w0 in the MSBs):
  - t = SubWord({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - SubWord is 4 parallel sbox_module instances, one per byte.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00). The Rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- Throughput: with rk_ready held high, RK0..RK10 appear on 11 consecutive cycles. done fires on the 12th cycle after the start edge.
- start while busy=1 is ignored. key_in is not re-sampled.
- start in the same cycle done=1 is legal: the block is already in IDLE. Back-to-back expansions therefore have a one-cycle gap.
- key_in is sampled only at an accepted start. Later changes have no effect.
- No combinational path from rk_ready to rk_valid or rk_data. All outputs are registered, or taken directly from registers.

Test Plan:
1. FIPS-197 key: start with key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> RK0 equals the key; RK1=a0fafe1788542cb123a339392a6c7605; RK10=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_idx 0..10 on consecutive cycles; done pulses once, one cycle after RK10.
2. All-zero key -> RK1=62636363626363636263636362636363; RK2=9b9898c9f9fbfbaa9b9898c9f9fbfbaa.
3. Backpressure: FIPS key with rk_ready toggled randomly -> rk_data and rk_idx stay stable while rk_valid&&!rk_ready; the accepted key sequence is identical to scenario 1; no key is skipped or duplicated.
4. Ignored start: pulse start with a different key at rk_idx=4 -> no effect; the sequence and done timing match scenario 1.
5. Reset mid-run: drive rst_n=0 at rk_idx=6 -> the next cycle has rk_valid=0, busy=0, done=0; a new start then yields RK0..RK10 correctly.
6. Back-to-back runs: assert start in the done cycle with the zero key -> RK0=0 appears on the next cycle with rk_idx=0 and rcon restarted (RK1 matches scenario 2). Separately, with NUM_ROUNDS=1 -> only RK0 and RK1 are emitted, followed by done.
